shared_adder_sched: RTL and testbench



---
 rtl/shared_adder_sched_pkg.sv | 14 +
 rtl/shared_adder_sched_nibble_adder_cin.sv | 25 ++
 rtl/shared_adder_sched.sv | 128 ++++++++++++
 tb/tb_shared_adder_sched.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/shared_adder_sched_pkg.sv
// Shared constants and types for the time-multiplexed nibble adder scheduler.
package shared_adder_sched_pkg;

  localparam int NIBBLE_W    = 4;
  localparam int IDX_W       = 3;
  localparam int MAX_NIBBLES = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/shared_adder_sched_nibble_adder_cin.sv
// 4-bit ripple-carry adder with carry-in, built from full-adder cells.
module nibble_adder_cin
  import shared_adder_sched_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] sum,
  output logic                cout
);

  logic [NIBBLE_W:0] carry;

  assign carry[0] = cin;

  generate
    for (genvar gi = 0; gi < NIBBLE_W; gi++) begin : g_fa
      assign sum[gi]     = a[gi] ^ b[gi] ^ carry[gi];
      assign carry[gi+1] = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
    end
  endgenerate

  assign cout = carry[NIBBLE_W];

endmodule

// File: rtl/shared_adder_sched.sv
// Two-requester scheduler that runs wide additions one nibble per cycle
// through a single shared 4-bit adder, LSB nibble first.
module shared_adder_sched
  import shared_adder_sched_pkg::*;
#(
  parameter int NIBBLES = 4,
  localparam int W = NIBBLE_W * NIBBLES
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0,
  input  logic [W-1:0] a0,
  input  logic [W-1:0] b0,
  input  logic         req1,
  input  logic [W-1:0] a1,
  input  logic [W-1:0] b1,
  output logic         ack0,
  output logic         ack1,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         busy,
  output logic         owner
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  state_t             state_reg;
  logic [W-1:0]       opa_reg;
  logic [W-1:0]       opb_reg;
  logic [W-1:0]       res_reg;
  logic [W-1:0]       res_next;
  logic               carry_reg;
  logic [IDX_W-1:0]   idx_reg;
  logic               last_grant_reg;

  logic [NIBBLE_W-1:0] opa_nib [MAX_NIBBLES];
  logic [NIBBLE_W-1:0] opb_nib [MAX_NIBBLES];
  logic [NIBBLE_W-1:0] nib_sum;
  logic                nib_cout;

  logic any_req;
  logic grant_idx;

  // Round-robin: on a tie the requester that was not served last wins.
  assign any_req   = req0 | req1;
  assign grant_idx = req1 & (~req0 | ~last_grant_reg);

  // Operand nibbles are padded out to the index range so idx never selects
  // past the array; unused slots are never reached for a legal NIBBLES.
  generate
    for (genvar gi = 0; gi < MAX_NIBBLES; gi++) begin : g_nib
      if (gi < NIBBLES) begin : g_used
        assign opa_nib[gi] = opa_reg[gi*NIBBLE_W +: NIBBLE_W];
        assign opb_nib[gi] = opb_reg[gi*NIBBLE_W +: NIBBLE_W];
        assign res_next[gi*NIBBLE_W +: NIBBLE_W] =
          (idx_reg == IDX_W'(gi)) ? nib_sum : res_reg[gi*NIBBLE_W +: NIBBLE_W];
      end else begin : g_pad
        assign opa_nib[gi] = '0;
        assign opb_nib[gi] = '0;
      end
    end
  endgenerate

  nibble_adder_cin u_adder (
    .a    (opa_nib[idx_reg]),
    .b    (opb_nib[idx_reg]),
    .cin  (carry_reg),
    .sum  (nib_sum),
    .cout (nib_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      opa_reg        <= '0;
      opb_reg        <= '0;
      res_reg        <= '0;
      carry_reg      <= 1'b0;
      idx_reg        <= '0;
      last_grant_reg <= 1'b1;
      sum            <= '0;
      cout           <= 1'b0;
      ack0           <= 1'b0;
      ack1           <= 1'b0;
      busy           <= 1'b0;
      owner          <= 1'b0;
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (any_req) begin
            opa_reg        <= grant_idx ? a1 : a0;
            opb_reg        <= grant_idx ? b1 : b0;
            owner          <= grant_idx;
            last_grant_reg <= grant_idx;
            carry_reg      <= 1'b0;
            idx_reg        <= '0;
            busy           <= 1'b1;
            state_reg      <= ADD;
          end
        end
        ADD: begin
          res_reg   <= res_next;
          carry_reg <= nib_cout;
          idx_reg   <= idx_reg + IDX_W'(1);
          if (idx_reg == LAST_IDX) begin
            // Result and ack are registered together so they appear in DONE.
            sum       <= res_next;
            cout      <= nib_cout;
            ack0      <= ~owner;
            ack1      <= owner;
            state_reg <= DONE;
          end
        end
        DONE: begin
          busy      <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          busy      <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shared_adder_sched.sv
// Directed self-checking bench for shared_adder_sched (NIBBLES=4 and NIBBLES=1).
module tb_shared_adder_sched;

  localparam int N = 4;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req0 = 1'b0, req1 = 1'b0;
  logic [W-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic         ack0, ack1, cout, busy, owner;
  logic [W-1:0] sum;

  logic         n1_req0 = 1'b0, n1_req1 = 1'b0;
  logic [3:0]   n1_a0 = '0, n1_b0 = '0, n1_a1 = '0, n1_b1 = '0;
  logic         n1_ack0, n1_ack1, n1_cout, n1_busy, n1_owner;
  logic [3:0]   n1_sum;

  int checks = 0;
  int errors = 0;

  shared_adder_sched #(.NIBBLES(N)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .a0(a0), .b0(b0),
    .req1(req1), .a1(a1), .b1(b1),
    .ack0(ack0), .ack1(ack1), .sum(sum), .cout(cout),
    .busy(busy), .owner(owner)
  );

  shared_adder_sched #(.NIBBLES(1)) dut_n1 (
    .clk(clk), .rst(rst),
    .req0(n1_req0), .a0(n1_a0), .b0(n1_b0),
    .req1(n1_req1), .a1(n1_a1), .b1(n1_b1),
    .ack0(n1_ack0), .ack1(n1_ack1), .sum(n1_sum), .cout(n1_cout),
    .busy(n1_busy), .owner(n1_owner)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
    tick; tick;
    checks++;
    if (sum !== 16'h0000) begin
      errors++; $display("FAIL reset_sum got %h want 0000", sum);
    end
    checks++;
    if ({ack0, ack1, busy, owner, cout} !== 5'b00000) begin
      errors++; $display("FAIL reset_flags got ack0/ack1/busy/owner/cout=%b want 00000",
                         {ack0, ack1, busy, owner, cout});
    end
    rst = 1'b0;
    $display("reset: sum=%h busy=%b owner=%b", sum, busy, owner);
  endtask

  // Single isolated request; checks exact ack timing (N edges after grant).
  task automatic do_op(input bit who, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] esum, input bit ecout, input string name);
    bit early;
    if (who) begin a1 = a; b1 = b; req1 = 1'b1; end
    else     begin a0 = a; b0 = b; req0 = 1'b1; end
    tick;
    req0 = 1'b0; req1 = 1'b0;
    checks++;
    if (busy !== 1'b1 || owner !== who) begin
      errors++; $display("FAIL %s_grant got busy=%b owner=%b want busy=1 owner=%0d", name, busy, owner, who);
    end
    early = 1'b0;
    for (int k = 1; k < N; k++) begin
      tick;
      if (ack0 !== 1'b0 || ack1 !== 1'b0) early = 1'b1;
    end
    checks++;
    if (early) begin
      errors++; $display("FAIL %s_early_ack got an ack before cycle %0d want none", name, N);
    end
    tick;
    checks++;
    if ({ack0, ack1} !== (who ? 2'b01 : 2'b10)) begin
      errors++; $display("FAIL %s_ack got ack0/ack1=%b%b want %b", name, ack0, ack1, who ? 2'b01 : 2'b10);
    end
    checks++;
    if (sum !== esum || cout !== ecout) begin
      errors++; $display("FAIL %s_result got sum=%h cout=%b want sum=%h cout=%b", name, sum, cout, esum, ecout);
    end
    $display("op %s: req%0d a=%h b=%h sum=%h cout=%b", name, who, a, b, sum, cout);
    tick;
    checks++;
    if ({ack0, ack1, busy} !== 3'b000) begin
      errors++; $display("FAIL %s_after got ack0/ack1/busy=%b want 000", name, {ack0, ack1, busy});
    end
  endtask

  task automatic test_single;
    do_op(1'b0, 16'h1234, 16'h1111, 16'h2345, 1'b0, "single");
    do_op(1'b1, 16'h9ABC, 16'h7654, 16'h1110, 1'b1, "single_r1");
  endtask

  task automatic test_carry;
    do_op(1'b0, 16'h0FFF, 16'h0001, 16'h1000, 1'b0, "carry_0fff");
    do_op(1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, "carry_ffff");
    do_op(1'b1, 16'h8000, 16'h8000, 16'h0000, 1'b1, "carry_8000");
  endtask

  task automatic test_back_to_back;
    int who_q[$];
    int cyc_q[$];
    logic [W-1:0] sum_q[$];
    bit both;
    bit drained;
    rst = 1'b1;
    tick;
    a0 = 16'd1; b0 = 16'd2; a1 = 16'd3; b1 = 16'd4;
    req0 = 1'b1; req1 = 1'b1;
    rst = 1'b0;
    both = 1'b0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      tick;
      if (ack0 === 1'b1 && ack1 === 1'b1) both = 1'b1;
      if (ack0 === 1'b1) begin who_q.push_back(0); cyc_q.push_back(cyc); sum_q.push_back(sum); end
      if (ack1 === 1'b1) begin who_q.push_back(1); cyc_q.push_back(cyc); sum_q.push_back(sum); end
    end
    req0 = 1'b0; req1 = 1'b0;
    checks++;
    if (both) begin
      errors++; $display("FAIL b2b_both_ack got simultaneous ack0 and ack1 want one at a time");
    end
    checks++;
    if (who_q.size() < 4) begin
      errors++; $display("FAIL b2b_count got %0d acks want at least 4", who_q.size());
    end else begin
      checks++;
      if (cyc_q[0] !== 4) begin
        errors++; $display("FAIL b2b_first_time got cycle %0d want 4", cyc_q[0]);
      end
      for (int i = 0; i < 4; i++) begin
        $display("b2b ack%0d at cycle %0d sum=%h", who_q[i], cyc_q[i], sum_q[i]);
        checks++;
        if (who_q[i] !== (i % 2) || sum_q[i] !== ((i % 2) ? 16'd7 : 16'd3)) begin
          errors++; $display("FAIL b2b_order%0d got ack%0d sum=%h want ack%0d sum=%h",
                             i, who_q[i], sum_q[i], i % 2, (i % 2) ? 16'd7 : 16'd3);
        end
        if (i > 0) begin
          checks++;
          if (cyc_q[i] - cyc_q[i-1] !== 6) begin
            errors++; $display("FAIL b2b_spacing%0d got %0d cycles want 6", i, cyc_q[i] - cyc_q[i-1]);
          end
        end
      end
    end
    drained = 1'b0;
    for (int k = 0; k < 20 && !drained; k++) begin
      tick;
      if (busy === 1'b0) drained = 1'b1;
    end
    checks++;
    if (!drained) begin
      errors++; $display("FAIL b2b_drain got busy=%b after 20 cycles want 0", busy);
    end
  endtask

  task automatic test_mid_events;
    bit early;
    a1 = 16'h1111; b1 = 16'h2222; req1 = 1'b1;
    tick;
    a1 = 16'hFFFF;
    tick;
    req1 = 1'b0;
    early = 1'b0;
    tick; if (ack0 !== 1'b0 || ack1 !== 1'b0) early = 1'b1;
    tick; if (ack0 !== 1'b0 || ack1 !== 1'b0) early = 1'b1;
    checks++;
    if (early) begin
      errors++; $display("FAIL mid_early_ack got an ack before completion want none");
    end
    tick;
    checks++;
    if ({ack0, ack1} !== 2'b01 || owner !== 1'b1) begin
      errors++; $display("FAIL mid_ack got ack0/ack1=%b%b owner=%b want 01 owner=1", ack0, ack1, owner);
    end
    checks++;
    if (sum !== 16'h3333 || cout !== 1'b0) begin
      errors++; $display("FAIL mid_result got sum=%h cout=%b want sum=3333 cout=0", sum, cout);
    end
    $display("mid: req1 dropped, a1 changed; sum=%h cout=%b", sum, cout);
    tick;
  endtask

  task automatic test_reset_mid;
    bit stray;
    a0 = 16'h1234; b0 = 16'h1111; req0 = 1'b1;
    tick;
    req0 = 1'b0;
    tick; tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || owner !== 1'b0) begin
      errors++; $display("FAIL rstmid_state got busy=%b owner=%b want 0 0", busy, owner);
    end
    checks++;
    if (sum !== 16'h0000 || cout !== 1'b0) begin
      errors++; $display("FAIL rstmid_result got sum=%h cout=%b want 0000 0", sum, cout);
    end
    stray = (ack0 !== 1'b0 || ack1 !== 1'b0);
    for (int k = 0; k < 10; k++) begin
      tick;
      if (ack0 !== 1'b0 || ack1 !== 1'b0 || busy !== 1'b0) stray = 1'b1;
    end
    checks++;
    if (stray) begin
      errors++; $display("FAIL rstmid_no_ack got ack or busy after aborted op want none");
    end
    $display("rstmid: aborted op, sum=%h busy=%b", sum, busy);
  endtask

  task automatic test_nibbles1(input logic [3:0] a, input logic [3:0] b,
                               input logic [3:0] esum, input bit ecout);
    n1_a0 = a; n1_b0 = b; n1_req0 = 1'b1;
    tick;
    n1_req0 = 1'b0;
    checks++;
    if (n1_busy !== 1'b1 || n1_ack0 !== 1'b0) begin
      errors++; $display("FAIL n1_grant got busy=%b ack0=%b want 1 0", n1_busy, n1_ack0);
    end
    tick;
    checks++;
    if (n1_ack0 !== 1'b1 || n1_ack1 !== 1'b0) begin
      errors++; $display("FAIL n1_ack got ack0/ack1=%b%b want 10", n1_ack0, n1_ack1);
    end
    checks++;
    if (n1_sum !== esum || n1_cout !== ecout) begin
      errors++; $display("FAIL n1_result got sum=%h cout=%b want sum=%h cout=%b", n1_sum, n1_cout, esum, ecout);
    end
    $display("n1: a=%h b=%h sum=%h cout=%b", a, b, n1_sum, n1_cout);
    tick;
    checks++;
    if (n1_busy !== 1'b0 || n1_ack0 !== 1'b0) begin
      errors++; $display("FAIL n1_after got busy=%b ack0=%b want 0 0", n1_busy, n1_ack0);
    end
  endtask

  initial begin
    test_reset;
    test_single;
    test_carry;
    test_back_to_back;
    test_mid_events;
    test_reset_mid;
    test_nibbles1(4'hF, 4'h1, 4'h0, 1'b1);
    test_nibbles1(4'h3, 4'h4, 4'h7, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
